// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - five-stage pipeline stall/flush controller
// Priority: memory wait, mul/div, redirect, load-use, normal flow.
module pipeline_hazard_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_is_load,
    input  logic        ex_branch_taken,
    input  logic        md_start,
    input  logic        md_done,
    input  logic        mem_req,
    input  logic        dmem_ready,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        mem_wb_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
    output logic        mem_wb_flush,
    output logic [15:0] stall_cycles,
    output logic        md_timeout
);

    typedef enum logic {RUN = 1'b0, MD_WAIT = 1'b1} state_t;

    state_t      state, state_nx;
    logic        done_pend, done_pend_nx;
    logic [7:0]  md_cnt, md_cnt_nx;
    logic        md_timeout_nx;
    logic        mem_wait, md_busy, md_complete, load_use;

    assign mem_wait    = mem_req && !dmem_ready;
    assign md_busy     = (state == RUN && md_start) ||
                         (state == MD_WAIT && !md_done && !done_pend);
    assign md_complete = (state == MD_WAIT) && (md_done || done_pend);
    // x0 is hardwired zero, so a load targeting it can never create a hazard
    assign load_use    = ex_is_load && (ex_rd != 5'd0) &&
                         ((id_uses_rs1 && id_rs1 == ex_rd) ||
                          (id_uses_rs2 && id_rs2 == ex_rd));

    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        ex_mem_en     = 1'b1;
        mem_wb_en     = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_flush  = 1'b0;
        mem_wb_flush  = 1'b0;
        state_nx      = state;
        done_pend_nx  = done_pend;
        md_cnt_nx     = md_cnt;
        md_timeout_nx = md_timeout;
        if (!rst_n) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_en    = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (mem_wait) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
            // a done pulse arriving while the whole pipe is frozen must not be lost
            if (state == MD_WAIT && md_done)
                done_pend_nx = 1'b1;
        end else if (md_busy) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_flush = 1'b1;
            if (state == RUN) begin
                state_nx  = MD_WAIT;
                md_cnt_nx = 8'd0;
            end else if (md_cnt != 8'hFF) begin
                md_cnt_nx = md_cnt + 8'd1;
                if (md_cnt == 8'hFE)
                    md_timeout_nx = 1'b1;
            end
        end else if (md_complete) begin
            state_nx     = RUN;
            done_pend_nx = 1'b0;
        end else if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            done_pend    <= 1'b0;
            md_cnt       <= 8'd0;
            md_timeout   <= 1'b0;
            stall_cycles <= 16'd0;
        end else begin
            state      <= state_nx;
            done_pend  <= done_pend_nx;
            md_cnt     <= md_cnt_nx;
            md_timeout <= md_timeout_nx;
            if (!pc_en && stall_cycles != 16'hFFFF)
                stall_cycles <= stall_cycles + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_uses_rs1, id_uses_rs2, ex_is_load, ex_branch_taken;
    logic        md_start, md_done, mem_req, dmem_ready;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic [15:0] stall_cycles;
    logic        md_timeout;

    int checks = 0;
    int errors = 0;

    pipeline_hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken),
        .md_start(md_start), .md_done(md_done),
        .mem_req(mem_req), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
        .stall_cycles(stall_cycles), .md_timeout(md_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // en = {pc, if_id, id_ex, ex_mem, mem_wb}; fl = {if_id, id_ex, ex_mem, mem_wb}
    task automatic chk_out(input string tag, input logic [4:0] en, input logic [3:0] fl);
        chk({tag, "_en"}, {11'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, {11'd0, en});
        chk({tag, "_fl"}, {12'd0, if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush}, {12'd0, fl});
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_rd = 5'd0; ex_is_load = 1'b0; ex_branch_taken = 1'b0;
        md_start = 1'b0; md_done = 1'b0; mem_req = 1'b0; dmem_ready = 1'b1;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        @(negedge clk); #1;
        chk_out("reset", 5'b00000, 4'b1111);
        chk("reset_stall", stall_cycles, 16'd0);
        chk("reset_tmo", {15'd0, md_timeout}, 16'd0);

        @(negedge clk); rst_n = 1'b1; idle(); #1;
        chk_out("idle", 5'b11111, 4'b0000);

        // load x5 in EX, decode reads rs2=x5
        @(negedge clk); idle(); ex_is_load = 1'b1; ex_rd = 5'd5;
        id_rs1 = 5'd3; id_uses_rs1 = 1'b1; id_rs2 = 5'd5; id_uses_rs2 = 1'b1; #1;
        chk_out("lu_rs2", 5'b00111, 4'b0100);
        @(negedge clk); idle(); #1;
        chk_out("lu_after", 5'b11111, 4'b0000);
        chk("lu_stall", stall_cycles, 16'd1);

        @(negedge clk); idle(); ex_is_load = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b1; #1;
        chk_out("lu_rs1", 5'b00111, 4'b0100);
        @(negedge clk); idle(); ex_is_load = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b0; #1;
        chk_out("lu_unused", 5'b11111, 4'b0000);
        chk("lu_stall2", stall_cycles, 16'd2);

        @(negedge clk); idle(); ex_is_load = 1'b1; ex_rd = 5'd0;
        id_rs1 = 5'd0; id_uses_rs1 = 1'b1; id_rs2 = 5'd0; id_uses_rs2 = 1'b1; #1;
        chk_out("lu_x0", 5'b11111, 4'b0000);

        @(negedge clk); idle(); ex_is_load = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_uses_rs2 = 1'b1;
        ex_branch_taken = 1'b1; #1;
        chk_out("br_lu", 5'b11111, 4'b1100);
        @(negedge clk); idle(); #1;
        chk("br_stall", stall_cycles, 16'd2);

        // md_start at cycle 0, md_done at cycle 4
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); idle(); md_start = 1'b1; #1;
            chk_out($sformatf("md_busy%0d", c), 5'b00011, 4'b0010);
        end
        @(negedge clk); idle(); md_start = 1'b1; md_done = 1'b1; #1;
        chk_out("md_done", 5'b11111, 4'b0000);
        @(negedge clk); idle(); #1;
        chk_out("md_run", 5'b11111, 4'b0000);
        chk("md_stall", stall_cycles, 16'd6);

        // mem wait inside MD_WAIT with md_done pulsed in the first frozen cycle
        @(negedge clk); idle(); md_start = 1'b1; #1;
        chk_out("mw_start", 5'b00011, 4'b0010);
        @(negedge clk); idle(); md_start = 1'b1; mem_req = 1'b1; dmem_ready = 1'b0; md_done = 1'b1; #1;
        chk_out("mw_freeze1", 5'b00000, 4'b0000);
        @(negedge clk); idle(); md_start = 1'b1; mem_req = 1'b1; dmem_ready = 1'b0; #1;
        chk_out("mw_freeze2", 5'b00000, 4'b0000);
        @(negedge clk); idle(); md_start = 1'b1; #1;
        chk_out("mw_pend", 5'b11111, 4'b0000);
        @(negedge clk); idle(); #1;
        chk_out("mw_run", 5'b11111, 4'b0000);
        chk("mw_stall", stall_cycles, 16'd9);

        @(negedge clk); idle(); md_done = 1'b1; #1;
        chk_out("done_in_run", 5'b11111, 4'b0000);
        @(negedge clk); idle(); mem_req = 1'b1; dmem_ready = 1'b0; ex_branch_taken = 1'b1; #1;
        chk_out("memwait_br", 5'b00000, 4'b0000);
        @(negedge clk); idle(); mem_req = 1'b1; dmem_ready = 1'b1; #1;
        chk_out("mem_ready", 5'b11111, 4'b0000);
        chk("memwait_stall", stall_cycles, 16'd10);

        // watchdog: no md_done for 300 MD_WAIT cycles
        @(negedge clk); idle(); md_start = 1'b1; #1;
        chk("wd_tmo0", {15'd0, md_timeout}, 16'd0);
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk); idle(); md_start = 1'b1; #1;
            chk($sformatf("wd_tmo_c%0d", k), {15'd0, md_timeout}, {15'd0, (k >= 256)});
        end
        chk_out("wd_still_busy", 5'b00011, 4'b0010);
        @(negedge clk); idle(); #1;
        chk("wd_stall", stall_cycles, 16'd311);
        rst_n = 1'b0; #1;
        chk_out("wd_reset", 5'b00000, 4'b1111);
        chk("wd_reset_tmo", {15'd0, md_timeout}, 16'd0);
        chk("wd_reset_stall", stall_cycles, 16'd0);
        @(negedge clk); rst_n = 1'b1; idle(); #1;
        chk_out("wd_run", 5'b11111, 4'b0000);
        @(negedge clk); #1;
        chk("wd_post_stall", stall_cycles, 16'd0);
        chk("wd_post_tmo", {15'd0, md_timeout}, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL provide the ports below, clock and reset first; one clock; reset is asynchronous and active-low.
REQ-002 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 id_rs1, id_rs2  in  5 each  decode-stage source register indices.
REQ-005 id_uses_rs1, id_uses_rs2  in  1 each  decode instruction actually reads that source.
REQ-006 ex_rd  in  5  execute-stage destination; ex_is_load  in  1  execute instruction is a load (opcode 0000011).
REQ-007 ex_branch_taken  in  1  taken branch/jump resolved in EX this cycle.
REQ-008 md_start  in  1  multi-cycle mul/div op present in EX; md_done  in  1  one-cycle result-valid pulse from mul/div unit.
REQ-009 mem_req  in  1  MEM stage accesses data memory; dmem_ready  in  1  data memory completes access this cycle.
REQ-010 pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register load enables.
REQ-011 if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  register loads a bubble (NOP 0x00000013, all control bits 0); flush overrides the same register's enable.
REQ-012 stall_cycles  out  16  saturating count of cycles with pc_en=0; md_timeout  out  1  sticky watchdog flag.

Function
REQ-013 Internal states: RUN, MD_WAIT; plus done_pend flag (1 bit) and md_cnt (8 bit).
REQ-014 Outputs combinational from state, done_pend and inputs; each cycle exactly one rule below applies, in priority order.
REQ-015 P1 mem wait (mem_req=1, dmem_ready=0): all five enables 0, all flushes 0; state and md_cnt held; md_done=1 this cycle sets done_pend.
REQ-016 P2 md busy (RUN with md_start=1, or MD_WAIT with md_done=0 and done_pend=0): pc_en, if_id_en, id_ex_en = 0; ex_mem_flush=1; mem_wb_en=1; RUN with md_start moves to MD_WAIT, md_cnt cleared to 0.
REQ-017 P2 md complete (MD_WAIT with md_done=1 or done_pend=1): all enables 1, no flush; next state RUN, done_pend cleared.
REQ-018 In MD_WAIT, md_cnt increments each P2-busy cycle, saturating at 255; reaching 255 sets md_timeout, which stays 1 until reset; FSM keeps waiting.
REQ-019 md_start ignored while in MD_WAIT; md_done ignored in RUN.
REQ-020 P3 redirect (ex_branch_taken=1): all enables 1, if_id_flush=1, id_ex_flush=1; PC loads target.
REQ-021 P4 load-use (ex_is_load=1, ex_rd!=0, and (id_uses_rs1 & id_rs1==ex_rd) or (id_uses_rs2 & id_rs2==ex_rd)): pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1, mem_wb_en=1; exactly one bubble per load-use pair.
REQ-022 P5 otherwise: all enables 1, all flushes 0.
REQ-023 Redirect and load-use same cycle: redirect wins (no stall).
REQ-024 Register x0 never triggers load-use.
REQ-025 stall_cycles increments by 1 on each clock where pc_en=0; holds at 0xFFFF.

Reset
REQ-026 While rst_n=0: state=RUN, done_pend=0, md_cnt=0, stall_cycles=0, md_timeout=0; all enables 0, all flushes 1.
REQ-027 Reset asserted mid-MD_WAIT or mid-mem-wait aborts immediately; first cycle after release evaluates in RUN with no pending state.

Verification
REQ-028 Load x5 in EX, decode reads rs2=x5 -> one cycle pc_en=0, if_id_en=0, id_ex_flush=1; next cycle all enables 1; stall_cycles=1.
REQ-029 Load to x0, decode reads x0 -> no stall, all enables 1.
REQ-030 md_start at cycle 0, md_done at cycle 4 -> cycles 0-3 pc_en=0, ex_mem_flush=1; cycle 4 all enables 1; stall_cycles=4; state RUN at cycle 5.
REQ-031 MD_WAIT with mem_req=1, dmem_ready=0 for 2 cycles, md_done pulsed in first -> both cycles all enables 0; third cycle md-complete outputs, then RUN.
REQ-032 ex_branch_taken=1 with simultaneous load-use -> if_id_flush=1, id_ex_flush=1, pc_en=1, stall_cycles unchanged.
REQ-033 md_start, no md_done for 300 cycles -> md_timeout=1 from 256th MD_WAIT cycle onward; rst_n pulse low -> md_timeout=0, stall_cycles=0, state RUN.
